register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
Parametrised multi-read-port register file for the core, successor to the 2-read/1-write file.
- Configurable read-port count, register depth, and optional write-to-read bypass.
- r0 optionally hardwired to zero.
- Integrated pending-write scoreboard: issue logic reserves a destination, writeback clears it.
- Each read reports whether its operand is still pending, so the pipeline can stall on RAW hazards without a separate scoreboard.

Parameters:
- ADDR_WIDTH, 4, register address width.
- DATA_WIDTH, 32, register data width.
- NUM_REGS, 16, number of architectural registers; must be ≤ 2**ADDR_WIDTH.
- NUM_READ, 2, number of read ports; 1..8.
- BYPASS, 1, 1 = same-cycle write forwarded to a read of the same address; 0 = read returns the pre-write value.
- ZERO_REG, 1, 1 = r0 reads 0, and writes/reserves to r0 are ignored; 0 = r0 is an ordinary register.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- write_en  input  1  commit write_data to write_addr this cycle.
- write_addr  input  ADDR_WIDTH  write destination.
- write_data  input  DATA_WIDTH  write value.
- reserve_en  input  1  mark reserve_addr pending (issue of an instruction writing it).
- reserve_addr  input  ADDR_WIDTH  register to reserve.
- read_en  input  NUM_READ  per-port read request.
- read_addr  input  NUM_READ*ADDR_WIDTH  port p uses bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- read_data  output  NUM_READ*DATA_WIDTH  port p uses bits [p*DATA_WIDTH +: DATA_WIDTH]; registered.
- read_valid  output  NUM_READ  read_data[p] updated by a read on the previous edge.
- read_busy  output  NUM_READ  the register read was pending at sample time; registered with read_data.
- busy_map  output  NUM_REGS  current scoreboard, bit i = register i pending; registered.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All registers cleared to 0.
  - busy_map = 0.
  - read_data = 0, read_valid = 0, read_busy = 0.
  - Effect is immediate, not waiting for clk.
  - Reset asserted mid-operation discards any in-flight read or write.
  - First edge after reset_n rises operates normally.
- Write, per clk edge:
  - If write_en, the address is in range (< NUM_REGS), and not (ZERO_REG && write_addr == 0): the register is updated at the edge.
  - Out-of-range addresses are ignored.
- Read latency is 1 cycle. On an edge where read_en[p] = 1:
  - read_data[p] is set as follows:
    - 0 if the address is out of range or (ZERO_REG && addr == 0).
    - Otherwise, if BYPASS and a qualifying write targets the same address this cycle: write_data.
    - Otherwise: the register's pre-edge value.
  - read_valid[p] = 1.
- On an edge where read_en[p] = 0: read_data[p] holds its previous value and read_valid[p] = 0.
- Ports are independent; any number of ports may read the same address in one cycle.
- Scoreboard set/clear per register i at each edge:
  - set = reserve_en && reserve_addr == i && valid target.
  - clr = write_en && write_addr == i && valid target.
  - set && clr on the same register: remains busy (reserve wins — the new producer is pending).
  - clr only: clears. set only: sets.
  - Reserving an already-busy register keeps it busy; no counting.
  - Valid target: in range, and not r0 when ZERO_REG = 1. With ZERO_REG = 1, busy_map[0] is always 0.
- read_busy[p]:
  - Samples the pre-edge busy state of the read address.
  - If BYPASS and a same-cycle clearing write hits that address, the operand is forwarded and read_busy[p] = 0.
  - If BYPASS = 0, read_busy[p] reflects the pre-edge busy bit.
  - Out-of-range or zero-register reads give 0.
  - Updated only when read_en[p] = 1; otherwise holds.
- No combinational paths from inputs to outputs.

Test Plan:
- Reset: write r3 = 0xDEADBEEF, then pulse reset_n low between edges → outputs clear immediately; next read of r3 → 0x00000000, read_valid = 1, read_busy = 0.
- Basic write/read, NUM_READ = 3: write r5 = 0x12345678, next cycle read r5 on ports 0, 1, 2 → all three read_data = 0x12345678 one cycle later.
- Zero register, ZERO_REG = 1: write r0 = 0xFFFFFFFF and reserve r0 → read r0 = 0, busy_map[0] = 0.
- Zero register, ZERO_REG = 0: write r0 = 0xFFFFFFFF → read r0 = 0xFFFFFFFF.
- Bypass, r7 = 0x1 and same-cycle write r7 = 0x2 with a read of r7:
  - BYPASS = 1 → read_data = 0x2, read_busy = 0.
  - BYPASS = 0 → read_data = 0x1.
- Scoreboard: reserve r4 → busy_map[4] = 1; read r4 → read_busy = 1; same-cycle reserve r4 and write r4 → stays 1; write r4 alone → busy_map[4] = 0.
- Out of range / hold, NUM_REGS = 12: write r13 → no state change; read r13 → 0. With read_en low for 3 cycles → read_data holds and read_valid = 0.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-read-port register file with an integrated pending-write scoreboard.
// Reads are registered (one-cycle latency); each read also reports its operand's busy state.
module register_file_mp #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           write_en,
    input  logic [ADDR_WIDTH-1:0]          write_addr,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic                           reserve_en,
    input  logic [ADDR_WIDTH-1:0]          reserve_addr,
    input  logic [NUM_READ-1:0]            read_en,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ-1:0]            read_valid,
    output logic [NUM_READ-1:0]            read_busy,
    output logic [NUM_REGS-1:0]            busy_map
);

    function automatic logic valid_target(input logic [ADDR_WIDTH-1:0] addr);
        return (32'(addr) < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_p1;
    logic [NUM_REGS-1:0]   busy_nxt;
    logic                  wr_hit;
    logic                  rsv_hit;

    logic [ADDR_WIDTH-1:0] rd_addr_p0 [NUM_READ];
    logic [DATA_WIDTH-1:0] rd_data_p0 [NUM_READ];
    logic [NUM_READ-1:0]   rd_busy_p0;

    logic [DATA_WIDTH-1:0] rd_data_p1 [NUM_READ];
    logic [NUM_READ-1:0]   rd_busy_p1;
    logic [NUM_READ-1:0]   vld_p1;

    assign wr_hit  = write_en && valid_target(write_addr);
    assign rsv_hit = reserve_en && valid_target(reserve_addr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (wr_hit) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (write_addr == ADDR_WIDTH'(i)) mem[i] <= write_data;
        end
    end

    // Scoreboard: a reserve on the same edge as the clearing write wins, since
    // it belongs to the newer producer of that register.
    always_comb begin
        busy_nxt = busy_p1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_hit && (write_addr == ADDR_WIDTH'(i)))    busy_nxt[i] = 1'b0;
            if (rsv_hit && (reserve_addr == ADDR_WIDTH'(i))) busy_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy_p1 <= '0;
        else          busy_p1 <= busy_nxt;
    end

    // Stage p0: per-port operand select with optional write forwarding
    always_comb begin
        for (int p = 0; p < NUM_READ; p++) begin
            rd_addr_p0[p] = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            rd_data_p0[p] = '0;
            rd_busy_p0[p] = 1'b0;
            if (valid_target(rd_addr_p0[p])) begin
                if ((BYPASS != 0) && wr_hit && (write_addr == rd_addr_p0[p])) begin
                    rd_data_p0[p] = write_data;
                end else begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (rd_addr_p0[p] == ADDR_WIDTH'(i)) begin
                            rd_data_p0[p] = mem[i];
                            rd_busy_p0[p] = busy_p1[i];
                        end
                    end
                end
            end
        end
    end

    // Stage p1: registered read results; data and busy hold when a port is idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1     <= '0;
            rd_busy_p1 <= '0;
            for (int p = 0; p < NUM_READ; p++) rd_data_p1[p] <= '0;
        end else begin
            vld_p1 <= read_en;
            for (int p = 0; p < NUM_READ; p++) begin
                if (read_en[p]) begin
                    rd_data_p1[p] <= rd_data_p0[p];
                    rd_busy_p1[p] <= rd_busy_p0[p];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_out
        assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_data_p1[p];
    end

    assign read_valid = vld_p1;
    assign read_busy  = rd_busy_p1;
    assign busy_map   = busy_p1;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: two configurations driven with the same directed stimulus
// and checked every cycle against an array-based model, plus literal spot checks.
module tb_register_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        write_en;
    logic [3:0]  write_addr;
    logic [31:0] write_data;
    logic        reserve_en;
    logic [3:0]  reserve_addr;
    logic [2:0]  ren;
    logic [3:0]  rport [3];

    logic [11:0] read_addr_a;
    logic [95:0] read_data_a;
    logic [2:0]  read_valid_a, read_busy_a;
    logic [11:0] busy_map_a;

    logic [1:0]  read_en_b;
    logic [7:0]  read_addr_b;
    logic [63:0] read_data_b;
    logic [1:0]  read_valid_b, read_busy_b;
    logic [15:0] busy_map_b;

    assign read_addr_a = {rport[2], rport[1], rport[0]};
    assign read_addr_b = {rport[1], rport[0]};
    assign read_en_b   = ren[1:0];

    // A: 3 ports, 12 regs, bypass, r0 hardwired.  B: 2 ports, 16 regs, no bypass, r0 ordinary.
    register_file_mp #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(12), .NUM_READ(3),
                       .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .reserve_en(reserve_en), .reserve_addr(reserve_addr),
        .read_en(ren), .read_addr(read_addr_a),
        .read_data(read_data_a), .read_valid(read_valid_a),
        .read_busy(read_busy_a), .busy_map(busy_map_a)
    );

    register_file_mp #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(16), .NUM_READ(2),
                       .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .reserve_en(reserve_en), .reserve_addr(reserve_addr),
        .read_en(read_en_b), .read_addr(read_addr_b),
        .read_data(read_data_b), .read_valid(read_valid_b),
        .read_busy(read_busy_b), .busy_map(busy_map_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 = config A, 1 = config B
    int nregs [2] = '{12, 16};
    int byp   [2] = '{1, 0};
    int zr    [2] = '{1, 0};
    int nrd   [2] = '{3, 2};

    logic [31:0] m_reg  [2][16];
    logic        m_busy [2][16];
    logic [31:0] e_data [2][3];
    logic        e_vld  [2][3];
    logic        e_busy [2][3];

    function automatic bit tgt(input int d, input logic [3:0] a);
        return (int'(a) < nregs[d]) && !(zr[d] == 1 && a == 4'd0);
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                m_reg[d][i]  = '0;
                m_busy[d][i] = 1'b0;
            end
            for (int p = 0; p < 3; p++) begin
                e_data[d][p] = '0;
                e_vld[d][p]  = 1'b0;
                e_busy[d][p] = 1'b0;
            end
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_clear();
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < nrd[d]; p++) begin
                    e_vld[d][p] = ren[p];
                    if (ren[p]) begin
                        if (!tgt(d, rport[p])) begin
                            e_data[d][p] = '0;
                            e_busy[d][p] = 1'b0;
                        end else if (byp[d] == 1 && write_en && tgt(d, write_addr)
                                     && write_addr == rport[p]) begin
                            e_data[d][p] = write_data;
                            e_busy[d][p] = 1'b0;
                        end else begin
                            e_data[d][p] = m_reg[d][rport[p]];
                            e_busy[d][p] = m_busy[d][rport[p]];
                        end
                    end
                end
                if (write_en && tgt(d, write_addr)) begin
                    m_reg[d][write_addr]  = write_data;
                    m_busy[d][write_addr] = 1'b0;
                end
                if (reserve_en && tgt(d, reserve_addr))
                    m_busy[d][reserve_addr] = 1'b1;
            end
        end
    end

    function automatic logic [95:0] x_data(input int d);
        logic [95:0] r = '0;
        for (int p = 0; p < nrd[d]; p++) r[p*32 +: 32] = e_data[d][p];
        return r;
    endfunction

    function automatic logic [2:0] x_vld(input int d);
        logic [2:0] r = '0;
        for (int p = 0; p < nrd[d]; p++) r[p] = e_vld[d][p];
        return r;
    endfunction

    function automatic logic [2:0] x_busy(input int d);
        logic [2:0] r = '0;
        for (int p = 0; p < nrd[d]; p++) r[p] = e_busy[d][p];
        return r;
    endfunction

    function automatic logic [15:0] x_map(input int d);
        logic [15:0] r = '0;
        for (int i = 0; i < nregs[d]; i++) r[i] = m_busy[d][i];
        return r;
    endfunction

    always @(negedge clk) begin
        if (cmp_on) begin
            check("A.read_data",  read_data_a,          x_data(0));
            check("A.read_valid", read_valid_a,         x_vld(0));
            check("A.read_busy",  read_busy_a,          x_busy(0));
            check("A.busy_map",   {4'b0, busy_map_a},   x_map(0));
            check("B.read_data",  {32'b0, read_data_b}, x_data(1));
            check("B.read_valid", read_valid_b,         x_vld(1));
            check("B.read_busy",  read_busy_b,          x_busy(1));
            check("B.busy_map",   busy_map_b,           x_map(1));
        end
    end

    task automatic idle();
        write_en   = 1'b0;
        reserve_en = 1'b0;
        ren        = 3'b000;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        write_en = 1'b1; write_addr = a; write_data = d;
    endtask

    task automatic rsv(input logic [3:0] a);
        reserve_en = 1'b1; reserve_addr = a;
    endtask

    task automatic rd(input logic [2:0] mask, input logic [3:0] a);
        ren = mask;
        for (int p = 0; p < 3; p++) rport[p] = a;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        rs;
        logic [3:0]  ra;
        logic [2:0]  rm;
        logic [3:0]  a0, a1, a2;
    } vec_t;

    vec_t tbl [8] = '{
        '{1'b1, 4'd5,  32'h0000_0055, 1'b0, 4'd0,  3'b001, 4'd5,  4'd0,  4'd0},
        '{1'b0, 4'd0,  32'h0,         1'b1, 4'd9,  3'b011, 4'd9,  4'd5,  4'd0},
        '{1'b1, 4'd9,  32'h0000_0099, 1'b0, 4'd0,  3'b111, 4'd9,  4'd9,  4'd11},
        '{1'b1, 4'd11, 32'h0000_000B, 1'b1, 4'd11, 3'b100, 4'd0,  4'd0,  4'd11},
        '{1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  3'b111, 4'd11, 4'd12, 4'd15},
        '{1'b1, 4'd15, 32'h0000_000F, 1'b0, 4'd0,  3'b010, 4'd0,  4'd15, 4'd0},
        '{1'b1, 4'd11, 32'h0000_0011, 1'b0, 4'd0,  3'b101, 4'd11, 4'd0,  4'd11},
        '{1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  3'b000, 4'd0,  4'd0,  4'd0}
    };

    initial begin
        reset_n = 1'b0;
        write_addr = '0; write_data = '0; reserve_addr = '0;
        for (int p = 0; p < 3; p++) rport[p] = '0;
        idle();
        repeat (2) @(negedge clk);
        cmp_on  = 1'b1;
        reset_n = 1'b1;
        check("lit.reset_map",   busy_map_a,   12'h000);
        check("lit.reset_valid", read_valid_a, 3'b000);

        // Populate r3, mark r2 busy, then reset asynchronously between edges
        wr(4'd3, 32'hDEAD_BEEF); rsv(4'd2); step();
        rd(3'b111, 4'd3); step();
        check("lit.r3_before_reset", read_data_a[31:0], 32'hDEAD_BEEF);
        check("lit.r2_busy",         busy_map_a[2],     1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("lit.async_data",  read_data_a,  96'h0);
        check("lit.async_valid", read_valid_a, 3'b000);
        check("lit.async_map",   busy_map_b,   16'h0000);
        #1 reset_n = 1'b1;
        @(negedge clk);
        rd(3'b111, 4'd3); step();
        check("lit.r3_after_reset", read_data_a,  96'h0);
        check("lit.r3_valid",       read_valid_a, 3'b111);
        check("lit.r3_busy",        read_busy_a,  3'b000);

        // All three ports read the same register
        wr(4'd5, 32'h1234_5678); step();
        rd(3'b111, 4'd5); step();
        check("lit.r5_3port", read_data_a, {3{32'h1234_5678}});

        // r0: hardwired in A, ordinary in B
        wr(4'd0, 32'hFFFF_FFFF); rsv(4'd0); step();
        rd(3'b111, 4'd0); step();
        check("lit.A_r0_data", read_data_a[31:0], 32'h0);
        check("lit.A_r0_busy", busy_map_a[0],     1'b0);
        check("lit.B_r0_data", read_data_b[31:0], 32'hFFFF_FFFF);
        check("lit.B_r0_busy", busy_map_b[0],     1'b1);
        wr(4'd0, 32'h0); step();

        // Same-cycle write and read of a busy r7
        wr(4'd7, 32'h1); step();
        rsv(4'd7); step();
        wr(4'd7, 32'h2); rd(3'b111, 4'd7); step();
        check("lit.A_byp_data", read_data_a[31:0], 32'h2);
        check("lit.A_byp_busy", read_busy_a,       3'b000);
        check("lit.B_nobyp_data", read_data_b[31:0], 32'h1);
        check("lit.B_nobyp_busy", read_busy_b,       2'b11);
        check("lit.A_r7_cleared", busy_map_a[7],     1'b0);

        // Scoreboard reserve / read / reserve+write / write
        rsv(4'd4); step();
        check("lit.r4_reserved", busy_map_a[4], 1'b1);
        rd(3'b111, 4'd4); step();
        check("lit.r4_read_busy", read_busy_a, 3'b111);
        rsv(4'd4); wr(4'd4, 32'h44); step();
        check("lit.r4_reserve_wins", busy_map_a[4], 1'b1);
        wr(4'd4, 32'h45); step();
        check("lit.r4_cleared", busy_map_a[4], 1'b0);

        // r13 is out of range for A, in range for B
        wr(4'd13, 32'hAAAA_5555); step();
        rsv(4'd13); step();
        rd(3'b111, 4'd13); step();
        check("lit.A_r13_data",  read_data_a,       96'h0);
        check("lit.A_r13_valid", read_valid_a,      3'b111);
        check("lit.A_map_oor",   busy_map_a,        12'h000);
        check("lit.B_r13_data",  read_data_b[31:0], 32'hAAAA_5555);
        check("lit.B_map_r13",   busy_map_b,        16'h2000);
        for (int k = 0; k < 3; k++) begin
            step();
            check("lit.hold_A_valid", read_valid_a,      3'b000);
            check("lit.hold_B_data",  read_data_b[31:0], 32'hAAAA_5555);
            check("lit.hold_B_busy",  read_busy_b,       2'b11);
        end

        // Mixed-traffic vectors, checked by the model
        for (int v = 0; v < 8; v++) begin
            write_en = tbl[v].we; write_addr = tbl[v].wa; write_data = tbl[v].wd;
            reserve_en = tbl[v].rs; reserve_addr = tbl[v].ra;
            ren = tbl[v].rm;
            rport[0] = tbl[v].a0; rport[1] = tbl[v].a1; rport[2] = tbl[v].a2;
            step();
        end
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
